// File: rtl/fetch_pkg.sv
// Shared types, constants and opcode-length/illegal-opcode rules for the 6502 fetch sequencer.
// FETCH_ILLEGAL_TRAP_EN (optional) enables illegal-opcode trapping in fetch_len_dec/fetch_seq.
package fetch_pkg;

  typedef enum logic [2:0] {
    VEC_LO,
    VEC_HI,
    OPC,
    OPR1,
    OPR2,
    ISSUE,
    HALT
  } fetch_state_t;

  localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;
  localparam logic [7:0]  OP_NOP            = 8'hEA;

  // Instruction length in bytes (1..3) from the opcode's aaabbbcc fields.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    cc  = op[1:0];
    bbb = op[4:2];
    if (op == 8'h20 || bbb == 3'b011 || bbb == 3'b111 || (bbb == 3'b110 && cc == 2'b01))
      op_len = 2'd3;
    else if (op == 8'h40 || op == 8'h60 ||
             ((bbb == 3'b010 || bbb == 3'b110) && (cc == 2'b00 || cc == 2'b10)))
      op_len = 2'd1;
    else
      op_len = 2'd2;
  endfunction

  // cc=11 column plus the x2 JAM/KIL opcodes.
  function automatic logic op_illegal(input logic [7:0] op);
    if (op[1:0] == 2'b11) begin
      op_illegal = 1'b1;
    end else begin
      case (op)
        8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 8'h52,
        8'h62, 8'h72, 8'h92, 8'hB2, 8'hD2, 8'hF2: op_illegal = 1'b1;
        default:                                  op_illegal = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/fetch_len_dec.sv
// Combinational opcode decoder: length and illegal flag. Shared with the disassembler/trace unit.
// Illegal flag is only produced when FETCH_ILLEGAL_TRAP_EN is defined; otherwise it is constant 0.
module fetch_len_dec
  import fetch_pkg::*;
(
  input  logic [7:0] op,
  output logic [1:0] len,
  output logic       illegal
);

  assign len = op_len(op);

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal = op_illegal(op);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/fetch_seq.sv
// 6502 instruction fetch sequencer: reset vector load, opcode/operand fetch, valid/ack issue.
// FETCH_ILLEGAL_TRAP_EN: illegal opcodes are issued flagged, then the sequencer halts until reset.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  output logic [15:0] addr,
  output logic        sync,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [1:0]  instr_len,
  output logic [15:0] pc_next,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic        illegal
);

  fetch_state_t state_reg, state_next;
  logic [15:0]  fetch_pc_reg, fetch_pc_next;
  logic [7:0]   opcode_reg, opcode_next;
  logic [15:0]  operand_reg, operand_next;
  logic [1:0]   len_reg, len_next;
  logic         illegal_reg, illegal_next;

  logic [1:0]   dec_len;
  logic         dec_illegal;

  fetch_len_dec u_len_dec (
    .op      (data),
    .len     (dec_len),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= VEC_LO;
      fetch_pc_reg <= 16'h0000;
      opcode_reg   <= OP_NOP;
      operand_reg  <= 16'h0000;
      len_reg      <= 2'd1;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      opcode_reg   <= opcode_next;
      operand_reg  <= operand_next;
      len_reg      <= len_next;
      illegal_reg  <= illegal_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    opcode_next   = opcode_reg;
    operand_next  = operand_reg;
    len_next      = len_reg;
    illegal_next  = illegal_reg;
    addr          = fetch_pc_reg;
    sync          = 1'b0;
    instr_valid   = 1'b0;

    case (state_reg)
      VEC_LO: begin
        addr               = RESET_VEC;
        fetch_pc_next[7:0] = data;
        state_next         = VEC_HI;
      end
      VEC_HI: begin
        addr                = RESET_VEC + 16'd1;
        fetch_pc_next[15:8] = data;
        state_next          = OPC;
      end
      OPC: begin
        sync          = 1'b1;
        opcode_next   = data;
        operand_next  = 16'h0000;
        len_next      = dec_len;
        illegal_next  = dec_illegal;
        fetch_pc_next = fetch_pc_reg + 16'd1;
        state_next    = (dec_len == 2'd1) ? ISSUE : OPR1;
      end
      OPR1: begin
        operand_next[7:0] = data;
        fetch_pc_next     = fetch_pc_reg + 16'd1;
        state_next        = (len_reg == 2'd3) ? OPR2 : ISSUE;
      end
      OPR2: begin
        operand_next[15:8] = data;
        fetch_pc_next      = fetch_pc_reg + 16'd1;
        state_next         = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
        if (instr_ack && illegal_reg) begin
          state_next = HALT;
        end else
`endif
        begin
          // A redirect lands in the PC right away so the next opcode fetch uses it.
          if (pc_load)
            fetch_pc_next = pc_in;
          if (instr_ack)
            state_next = OPC;
        end
      end
      // HALT: address frozen on the PC, nothing issued; only reset leaves.
      default: ;
    endcase
  end

  assign opcode    = opcode_reg;
  assign operand   = operand_reg;
  assign instr_len = len_reg;
  assign pc_next   = fetch_pc_reg;
  assign illegal   = illegal_reg;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- 6502-core instruction fetch sequencer; the producer side of the opcode-latch interface.
- After reset, loads PC from the reset vector. Then per instruction:
  - drives the address bus;
  - asserts sync on the opcode cycle;
  - captures opcode plus 0-2 operand bytes;
  - hands one complete instruction to the execute stage via a valid/ack handshake.
- Sits between the memory bus and the execute/decoder logic.

Parameters:
- RESET_VEC, 16'hFFFC, address of reset vector low byte; high byte at RESET_VEC+1.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- data  in  8  memory read data; combinational, valid in the same cycle as addr.
- addr  out  16  memory address.
- sync  out  1  high only during the opcode fetch cycle.
- instr_valid  out  1  complete instruction available.
- instr_ack  in  1  execute stage accepts instruction.
- opcode  out  8  fetched opcode.
- operand  out  16  operand bytes {hi,lo}; unused bytes are zero.
- instr_len  out  2  instruction length, 1..3.
- pc_next  out  16  address following the instruction.
- pc_load  in  1  redirect request (jump/branch/interrupt).
- pc_in  in  16  redirect target.
- illegal  out  1  illegal-opcode trap (see Optional Feature).

Behaviour:
- Reset (async, rst=1) sets:
  - state=VEC_LO, pc=0, addr=RESET_VEC;
  - sync=0, instr_valid=0, opcode=8'hEA, operand=0, instr_len=1, pc_next=0, illegal=0.
- FSM states: VEC_LO, VEC_HI, OPC, OPR1, OPR2, ISSUE, HALT.
- VEC_LO: addr=RESET_VEC; pc[7:0]<=data; go to VEC_HI.
- VEC_HI: addr=RESET_VEC+1; pc[15:8]<=data; go to OPC.
- OPC:
  - addr=pc, sync=1; opcode<=data; pc<=pc+1; operand<=0; instr_len<=len(data).
  - Go to ISSUE if len=1, else OPR1.
- OPR1: addr=pc; operand[7:0]<=data; pc<=pc+1; go to OPR2 if len=3, else ISSUE.
- OPR2: addr=pc; operand[15:8]<=data; pc<=pc+1; go to ISSUE.
- ISSUE:
  - instr_valid=1, pc_next=pc; addr holds pc; opcode/operand stable.
  - instr_ack=1 → next cycle is OPC.
  - pc_load=1 with ack → pc<=pc_in, and the fetch uses pc_in.
  - pc_load without ack: pc<=pc_in immediately; instr_valid stays high.
  - pc_load outside ISSUE is ignored.
- Latency: first sync occurs in the 3rd cycle after rst deasserts. Per instruction: len fetch cycles + ≥1 ISSUE cycle.
- PC arithmetic is 16-bit and wraps (FFFF+1=0000). RESET_VEC+1 also wraps.
- Length rule, with cc=op[1:0], bbb=op[4:2]:
  - 3 bytes: op=20; bbb=011; bbb=111; or bbb=110 with cc=01.
  - 1 byte: op∈{40,60}; bbb∈{010,110} with cc∈{00,10}.
  - 2 bytes: everything else, including BRK=00 (signature byte).
- Reset mid-instruction aborts immediately; refetches the vector.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes with cc=11, or op∈{02,12,22,32,42,52,62,72,92,B2,D2,F2}, are issued normally with illegal=1.
  - After ack, the FSM enters HALT: sync=0, instr_valid=0, addr frozen. It leaves only on reset.
- Undefined: illegal is tied 0; such opcodes use the normal length rule; no HALT state is synthesized.

Decomposition:
- Package fetch_pkg:
  - state enum;
  - RESET_VEC default;
  - OP_NOP=8'hEA;
  - functions op_len(op) and op_illegal(op).
- Sub-module fetch_len_dec: combinational opcode → {len, illegal}, reused later by the disassembler/trace unit.

Test Plan:
- Reset vector: mem[FFFC]=00, mem[FFFD]=C0 → addr FFFC, FFFD, then C000 with sync=1 on cycle 3.
- Length mix: C000: A9 42 / 8D 00 02 / EA, each acked immediately. Expected issues:
  - opcode A9, operand 0042, len 2, pc_next C002;
  - opcode 8D, operand 0200, len 3, pc_next C005;
  - opcode EA, operand 0000, len 1, pc_next C006.
  - sync high only at C000, C002, C005.
- Backpressure: hold instr_ack=0 for 5 cycles in ISSUE → instr_valid, opcode and operand stable; no sync; addr unchanged.
- Redirect: pc_load=1, pc_in=1234 with ack → next cycle addr=1234, sync=1. pc_load asserted during OPR1 has no effect.
- Wrap: vector=FFFE, mem[FFFE]=4C 00 80 → operand bytes read from FFFF then 0000; operand=8000; pc_next=0001.
- Trap (macro on): opcode 02 → illegal=1 with instr_valid. After ack, addr frozen and sync stays 0 for 10 cycles. rst mid-HALT → refetch from FFFC.
